fifo_write_arbiter: RTL and testbench

//  Shares one async_fifo write port among NUM_REQ producers; the FIFO then feeds the aggregator.

---
 rtl/fifo_write_arbiter_pkg.sv | 16 +
 rtl/fifo_write_arbiter_if.sv | 24 ++
 rtl/fifo_write_arbiter_rr_pick.sv | 31 +++
 rtl/fifo_write_arbiter.sv | 118 +++++++++++
 tb/tb_fifo_write_arbiter.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_write_arbiter_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_t;

  // Index width for n items, never narrower than one bit.
  function automatic int id_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// Producer-side handshake plus async_fifo write-port signals shared by the arbiter.
interface fifo_write_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 11
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic [DATA_WIDTH-1:0]         fifo_wdata;
  logic                          fifo_wreq;
  logic                          fifo_wfull;

  // The arbiter owns ready and the FIFO write strobe/data.
  modport master (
    input  req_valid, req_data, fifo_wfull,
    output req_ready, fifo_wdata, fifo_wreq
  );

  // Producers and the FIFO model sit on this side.
  modport slave (
    output req_valid, req_data, fifo_wfull,
    input  req_ready, fifo_wdata, fifo_wreq
  );
endinterface

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after last_i, wrapping.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDW     = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDW-1:0]     last_i,
  output logic               found_o,
  output logic [IDW-1:0]     next_o
);

  logic [IDW-1:0] idx;

  // Scan farthest-to-nearest so the nearest requester after last_i wins.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    found_o = 1'b0;
    next_o  = '0;
    idx     = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      idx = IDW'((int'(last_i) + off) % NUM_REQ);
      if (req_i[idx]) begin
        found_o = 1'b1;
        next_o  = idx;
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one async_fifo write port among NUM_REQ producers.
// A grant is held for exactly BURST_LEN accepted words; one IDLE cycle arbitrates.
// Optional feature macro: ARB_STATS_EN adds stat_bursts (saturating completed-burst counters).
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 11,
  parameter  int BURST_LEN  = 2,
  parameter  int CNT_WIDTH  = 16,
  localparam int IDW        = id_width(NUM_REQ),
  localparam int BEAT_W     = id_width(BURST_LEN)
) (
  input  logic                          clk,
  input  logic                          wrst_n,
  fifo_write_arbiter_if.master          bus,
  output logic [IDW-1:0]                grant_id,
  output logic                          busy
`ifdef ARB_STATS_EN
  ,
  output logic [NUM_REQ*CNT_WIDTH-1:0]  stat_bursts
`endif
);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  arb_state_t      state_q, state_d;
  logic [IDW-1:0]  grant_q, grant_d;
  logic [IDW-1:0]  last_q, last_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic            pick_found;
  logic [IDW-1:0]  pick_idx;
  logic            wreq;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_i   (bus.req_valid),
    .last_i  (last_q),
    .found_o (pick_found),
    .next_o  (pick_idx)
  );

  // Next-state and handshake outputs; nothing transfers while IDLE or in reset.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    beat_d  = beat_q;
    wreq    = 1'b0;
    bus.req_ready = '0;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          beat_d  = '0;
          state_d = ARB_BURST;
        end
      end
      ARB_BURST: begin
        wreq = wrst_n & bus.req_valid[grant_q] & ~bus.fifo_wfull;
        bus.req_ready[grant_q] = wreq;
        if (wreq) begin
          if (beat_q == LAST_BEAT) begin
            last_d  = grant_q;
            beat_d  = '0;
            state_d = ARB_IDLE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset; producer 0 wins first after reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!wrst_n) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      last_q  <= IDW'(NUM_REQ - 1);
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
    end
  end

  assign bus.fifo_wreq  = wreq;
  assign bus.fifo_wdata = bus.req_data[grant_q*DATA_WIDTH +: DATA_WIDTH];
  assign grant_id       = grant_q;
  assign busy           = (state_q == ARB_BURST);

`ifdef ARB_STATS_EN
  logic [CNT_WIDTH-1:0] cnt_q [NUM_REQ];
  logic                 burst_done;

  assign burst_done = wreq && (beat_q == LAST_BEAT);

  // Per-producer completed-burst counters, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (!wrst_n) begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else if (burst_done && (cnt_q[grant_q] != '1)) begin
      cnt_q[grant_q] <= cnt_q[grant_q] + 1'b1;
    end
  end

  // Flatten the counters onto the statistics port.
  always_comb begin
    stat_bursts = '0;
    for (int i = 0; i < NUM_REQ; i++) stat_bursts[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q[i];
  end
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench for fifo_write_arbiter: directed scenarios plus randomized
// traffic compared against a transaction-level model (owner, words left, last winner).
module tb_fifo_write_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int DATA_WIDTH = 11;
  localparam int BURST_LEN  = 2;
  localparam int CNT_WIDTH  = 2;
  localparam int IDW        = 2;

  logic           clk = 1'b0;
  logic           wrst_n;
  logic [IDW-1:0] grant_id;
  logic           busy;
`ifdef ARB_STATS_EN
  logic [NUM_REQ*CNT_WIDTH-1:0] stat_bursts;
`endif

  int checks = 0;
  int errors = 0;

  fifo_write_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH)) bus ();

  fifo_write_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .BURST_LEN(BURST_LEN), .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk      (clk),
    .wrst_n   (wrst_n),
    .bus      (bus.master),
    .grant_id (grant_id),
    .busy     (busy)
`ifdef ARB_STATS_EN
    ,
    .stat_bursts (stat_bursts)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: who owns the port (-1 = nobody), words still owed, last winner.
  int m_owner = -1;
  int m_left  = 0;
  int m_last  = NUM_REQ - 1;
  int m_stats [NUM_REQ];
  int prod_n  [NUM_REQ];

  logic                  exp_busy, exp_wreq, obs_busy, obs_wreq;
  logic [NUM_REQ-1:0]    exp_ready, obs_ready;
  int                    exp_grant, obs_grant;
  logic [DATA_WIDTH-1:0] exp_wdata, obs_wdata;
  logic [DATA_WIDTH-1:0] wr_q [$];

  function automatic logic [DATA_WIDTH-1:0] word_of(input int p);
    return DATA_WIDTH'(p * 16 + (prod_n[p] % 16));
  endfunction

  // One clock: drive at the falling edge, sample 1 ns later, then advance the model.
  task automatic cycle(input logic [NUM_REQ-1:0] v, input logic full, input logic rst_n);
    int found;
    @(negedge clk);
    bus.req_valid  = v;
    bus.fifo_wfull = full;
    wrst_n         = rst_n;
    for (int i = 0; i < NUM_REQ; i++) bus.req_data[i*DATA_WIDTH +: DATA_WIDTH] = word_of(i);
    #1;
    exp_busy  = (m_owner >= 0);
    exp_wreq  = rst_n && exp_busy && v[m_owner] && !full;
    exp_ready = exp_wreq ? NUM_REQ'(1 << m_owner) : '0;
    exp_grant = m_owner;
    exp_wdata = exp_busy ? word_of(m_owner) : '0;
    obs_busy  = busy;
    obs_wreq  = bus.fifo_wreq;
    obs_ready = bus.req_ready;
    obs_grant = int'(grant_id);
    obs_wdata = bus.fifo_wdata;
    if (obs_wreq === 1'b1) wr_q.push_back(obs_wdata);
    if (!rst_n) begin
      m_owner = -1;
      m_left  = 0;
      m_last  = NUM_REQ - 1;
      for (int i = 0; i < NUM_REQ; i++) m_stats[i] = 0;
    end else if (!exp_busy) begin
      found = 0;
      for (int off = 1; off <= NUM_REQ; off++) begin
        if (!found && v[(m_last + off) % NUM_REQ]) begin
          found   = 1;
          m_owner = (m_last + off) % NUM_REQ;
          m_left  = BURST_LEN;
        end
      end
    end else if (exp_wreq) begin
      prod_n[m_owner]++;
      m_left--;
      if (m_left == 0) begin
        if (m_stats[m_owner] < (1 << CNT_WIDTH) - 1) m_stats[m_owner]++;
        m_last  = m_owner;
        m_owner = -1;
      end
    end
  endtask

  task automatic test_reset();
    cycle('1, 1'b0, 1'b0);
    cycle('1, 1'b0, 1'b0);
    checks += 3;
    if (obs_wreq !== 1'b0) begin errors++; $display("FAIL reset_wreq got=%b want=0", obs_wreq); end
    if (obs_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", obs_busy); end
    if (obs_ready !== '0) begin errors++; $display("FAIL reset_ready got=%b want=0", obs_ready); end
    cycle('1, 1'b0, 1'b1);
    checks++;
    if (obs_busy !== 1'b0) begin errors++; $display("FAIL reset_arb_bubble busy=%b want=0", obs_busy); end
    cycle('1, 1'b0, 1'b1);
    checks += 2;
    if (obs_busy !== 1'b1) begin errors++; $display("FAIL reset_first_busy got=%b want=1", obs_busy); end
    if (obs_grant !== 0) begin errors++; $display("FAIL reset_first_grant got=%0d want=0", obs_grant); end
  endtask

  task automatic test_fairness();
    int k, j;
    logic [DATA_WIDTH-1:0] want;
    cycle('0, 1'b0, 1'b0);
    for (int i = 0; i < NUM_REQ; i++) prod_n[i] = 0;
    wr_q.delete();
    for (int c = 0; c < 26; c++) cycle('1, 1'b0, 1'b1);
    checks++;
    if (wr_q.size() < 16) begin
      errors++; $display("FAIL fair_count got=%0d want>=16", wr_q.size());
    end else begin
      for (int w = 0; w < 16; w++) begin
        k = w / BURST_LEN;
        j = w % BURST_LEN;
        want = DATA_WIDTH'((k % NUM_REQ) * 16 + (k / NUM_REQ) * BURST_LEN + j);
        checks++;
        if (wr_q[w] !== want) begin
          errors++; $display("FAIL fair_word[%0d] got=%0d want=%0d", w, wr_q[w], want);
        end
      end
    end
  endtask

  task automatic test_full_stall();
    cycle('0, 1'b0, 1'b0);
    wr_q.delete();
    cycle(4'b0100, 1'b0, 1'b1);
    cycle(4'b0100, 1'b0, 1'b1);
    checks += 2;
    if (obs_wreq !== 1'b1) begin errors++; $display("FAIL stall_beat0 wreq=%b want=1", obs_wreq); end
    if (obs_grant !== 2) begin errors++; $display("FAIL stall_beat0_grant got=%0d want=2", obs_grant); end
    for (int c = 0; c < 5; c++) begin
      cycle(4'b0100, 1'b1, 1'b1);
      checks += 3;
      if (obs_wreq !== 1'b0) begin errors++; $display("FAIL stall_wreq c%0d got=%b want=0", c, obs_wreq); end
      if (obs_busy !== 1'b1) begin errors++; $display("FAIL stall_busy c%0d got=%b want=1", c, obs_busy); end
      if (obs_grant !== 2) begin errors++; $display("FAIL stall_grant c%0d got=%0d want=2", c, obs_grant); end
    end
    cycle(4'b0100, 1'b0, 1'b1);
    checks += 2;
    if (obs_wreq !== 1'b1) begin errors++; $display("FAIL stall_release wreq=%b want=1", obs_wreq); end
    if (obs_ready !== 4'b0100) begin errors++; $display("FAIL stall_ready got=%b want=0100", obs_ready); end
    cycle(4'b0100, 1'b0, 1'b1);
    checks += 2;
    if (obs_busy !== 1'b0) begin errors++; $display("FAIL stall_idle busy=%b want=0", obs_busy); end
    if (wr_q.size() !== 2) begin errors++; $display("FAIL stall_writes got=%0d want=2", wr_q.size()); end
  endtask

  task automatic test_owner_drop();
    cycle('0, 1'b0, 1'b0);
    cycle(4'b1010, 1'b0, 1'b1);
    cycle(4'b1010, 1'b0, 1'b1);
    checks++;
    if (obs_grant !== 1) begin errors++; $display("FAIL drop_first_grant got=%0d want=1", obs_grant); end
    for (int c = 0; c < 3; c++) begin
      cycle(4'b1000, 1'b0, 1'b1);
      checks += 3;
      if (obs_busy !== 1'b1) begin errors++; $display("FAIL drop_busy c%0d got=%b want=1", c, obs_busy); end
      if (obs_grant !== 1) begin errors++; $display("FAIL drop_grant c%0d got=%0d want=1", c, obs_grant); end
      if (obs_wreq !== 1'b0) begin errors++; $display("FAIL drop_wreq c%0d got=%b want=0", c, obs_wreq); end
    end
    cycle(4'b1010, 1'b0, 1'b1);
    checks++;
    if (obs_ready !== 4'b0010) begin errors++; $display("FAIL drop_beat1 ready=%b want=0010", obs_ready); end
    cycle(4'b1010, 1'b0, 1'b1);
    checks++;
    if (obs_busy !== 1'b0) begin errors++; $display("FAIL drop_idle busy=%b want=0", obs_busy); end
    cycle(4'b1010, 1'b0, 1'b1);
    checks++;
    if (obs_grant !== 3) begin errors++; $display("FAIL drop_next_grant got=%0d want=3", obs_grant); end
  endtask

  task automatic test_reset_mid_burst();
    cycle('0, 1'b0, 1'b0);
    cycle(4'b1000, 1'b0, 1'b1);
    cycle(4'b1000, 1'b0, 1'b1);
    cycle(4'b1001, 1'b0, 1'b0);
    checks++;
    if (obs_wreq !== 1'b0) begin errors++; $display("FAIL midrst_wreq got=%b want=0", obs_wreq); end
    wr_q.delete();
    cycle(4'b1001, 1'b0, 1'b1);
    checks++;
    if (obs_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b want=0", obs_busy); end
    cycle(4'b1001, 1'b0, 1'b1);
    cycle(4'b1001, 1'b0, 1'b1);
    checks++;
    if (obs_grant !== 0) begin errors++; $display("FAIL midrst_grant got=%0d want=0", obs_grant); end
    cycle(4'b1001, 1'b0, 1'b1);
    checks += 2;
    if (obs_busy !== 1'b0) begin errors++; $display("FAIL midrst_end busy=%b want=0", obs_busy); end
    if (wr_q.size() !== BURST_LEN) begin
      errors++; $display("FAIL midrst_words got=%0d want=%0d", wr_q.size(), BURST_LEN);
    end
  endtask

`ifdef ARB_STATS_EN
  task automatic test_stats_saturate();
    cycle('0, 1'b0, 1'b0);
    for (int c = 0; c < 16; c++) cycle(4'b0001, 1'b0, 1'b1);
    for (int i = 0; i < NUM_REQ; i++) begin
      checks++;
      if (stat_bursts[i*CNT_WIDTH +: CNT_WIDTH] !== CNT_WIDTH'(i == 0 ? 3 : 0)) begin
        errors++;
        $display("FAIL stats_sat[%0d] got=%0d want=%0d", i, stat_bursts[i*CNT_WIDTH +: CNT_WIDTH], (i == 0) ? 3 : 0);
      end
    end
  endtask
`endif

  task automatic test_random();
    logic [NUM_REQ-1:0] v;
    logic full, rst_n;
    cycle('0, 1'b0, 1'b0);
    for (int c = 0; c < 400; c++) begin
      v     = NUM_REQ'($urandom);
      full  = ($urandom_range(0, 3) == 0);
      rst_n = ($urandom_range(0, 39) != 0);
      cycle(v, full, rst_n);
      checks += 3;
      if (obs_busy !== exp_busy) begin errors++; $display("FAIL rnd_busy c%0d got=%b want=%b", c, obs_busy, exp_busy); end
      if (obs_wreq !== exp_wreq) begin errors++; $display("FAIL rnd_wreq c%0d got=%b want=%b", c, obs_wreq, exp_wreq); end
      if (obs_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready c%0d got=%b want=%b", c, obs_ready, exp_ready); end
      if (exp_busy) begin
        checks += 2;
        if (obs_grant !== exp_grant) begin errors++; $display("FAIL rnd_grant c%0d got=%0d want=%0d", c, obs_grant, exp_grant); end
        if (obs_wdata !== exp_wdata) begin errors++; $display("FAIL rnd_wdata c%0d got=%0d want=%0d", c, obs_wdata, exp_wdata); end
      end
`ifdef ARB_STATS_EN
      for (int i = 0; i < NUM_REQ; i++) begin
        checks++;
        if (stat_bursts[i*CNT_WIDTH +: CNT_WIDTH] !== CNT_WIDTH'(m_stats[i])) begin
          errors++;
          $display("FAIL rnd_stat[%0d] c%0d got=%0d want=%0d", i, c, stat_bursts[i*CNT_WIDTH +: CNT_WIDTH], m_stats[i]);
        end
      end
`endif
    end
  endtask

  initial begin
    wrst_n         = 1'b0;
    bus.req_valid  = '0;
    bus.req_data   = '0;
    bus.fifo_wfull = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      m_stats[i] = 0;
      prod_n[i]  = 0;
    end
    test_reset();
    test_fairness();
    test_full_stall();
    test_owner_drop();
    test_reset_mid_burst();
`ifdef ARB_STATS_EN
    test_stats_saturate();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
